// File: rtl/mem_pkg.sv
// Purpose: shared constants for the data-memory responder (widths, FSM encoding, legal LATENCY range).
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    // FSM encoding kept as plain 2-bit constants so older tools and waveform
    // viewers see stable numeric values.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Legal response latency range; the 4-bit counter covers up to 15.
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// Purpose: request/response handshake bundle between the core's load/store path and the responder.
// Latency: n/a (wires only).
// Backpressure: req_valid held by master until req_ready; rsp held by slave until rsp_ready.
// Ports (signals): req_valid/req_ready/req_write/req_addr/req_wdata/req_be,
//                  rsp_valid/rsp_ready/rsp_rdata/rsp_err.
interface dmem_responder_if;
    import mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    // Initiator (core) side.
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Responder (memory) side.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Purpose: single-port synchronous word RAM with byte-enable write and registered read; no reset.
// Latency: read data appears one edge after an enabled read; write lands on the enabled edge.
// Backpressure: none; one access per enabled cycle, read data held until the next enabled read.
// Ports: clk, en_i (access strobe), we_i (1 = write), be_i, addr_i (word index), wdata_i, rdata_o.
module dmem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Purpose: fixed-latency handshaked responder for CPU word loads/stores over an on-chip word array.
// Latency: rsp_valid rises LATENCY cycles after the accept cycle; request-to-request spacing LATENCY+1.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready, cleared the edge after.
// Ports: clk, rst_n (async active-low), bus (dmem_responder_if.slave: req_* in, rsp_* out).
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  bus
);

    localparam int                AW       = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("dmem_responder: LATENCY out of range 1..15");
    end
    if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("dmem_responder: DEPTH_WORDS must be a power of 2 and >= 4");
    end

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              err_q, err_d;
    logic              ld_q, ld_d;     // response carries load data from the array

    logic              accept;
    logic              commit;
    logic              cur_write;
    logic [WORD_W-1:0] cur_addr;
    logic [WORD_W-1:0] cur_wdata;
    logic [BE_W-1:0]   cur_be;
    logic              addr_err;
    logic [WORD_W-1:0] ram_rdata;

    assign accept = bus.req_valid & (state_q == ST_IDLE);

    // With LATENCY=1 the commit edge is the accept edge itself, so the live
    // request is used; otherwise the captured copy is used.
    assign cur_write = (state_q == ST_IDLE) ? bus.req_write : wr_q;
    assign cur_addr  = (state_q == ST_IDLE) ? bus.req_addr  : addr_q;
    assign cur_wdata = (state_q == ST_IDLE) ? bus.req_wdata : wdata_q;
    assign cur_be    = (state_q == ST_IDLE) ? bus.req_be    : be_q;

    assign addr_err = (cur_addr[1:0] != 2'b00) |
                      (cur_addr[WORD_W-1:2] >= (WORD_W-2)'(DEPTH_WORDS));

    // Commit happens on the edge that enters RESP. Gated by rst_n so nothing
    // reaches the array while reset is held.
    assign commit = rst_n & ((LATENCY == 1) ? accept
                                            : (state_q == ST_BUSY && cnt_q == LAST_CNT));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ld_d    = ld_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (LATENCY > 1) begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                    ld_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (commit) begin
            err_d = addr_err;
            ld_d  = ~cur_write & ~addr_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ld_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ld_q    <= ld_d;
            if (accept) begin
                wr_q    <= bus.req_write;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                be_q    <= bus.req_be;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .en_i    (commit & ~addr_err),
        .we_i    (cur_write),
        .be_i    (cur_be),
        .addr_i  (cur_addr[AW+1:2]),
        .wdata_i (cur_wdata),
        .rdata_o (ram_rdata)
    );

    // The array read register is only loaded on a load commit, so gating it
    // with ld_q keeps rsp_rdata stable while held and zero otherwise.
    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_err   = err_q;
    assign bus.rsp_rdata = ld_q ? ram_rdata : '0;

endmodule
